spi_mem_loader: RTL

- Sits between the SPI byte receiver and the three processor memories (activation, parameter, instruction).
- Takes an 8-bit received byte stream framed by chip-select, decodes a header byte to select the target memory, and loads a 16-bit start address.
- Packs the following bytes MSB-first into words of the target memory width, then issues one write strobe per completed word with an auto-incrementing address.

---
 rtl/spi_mem_loader.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/spi_mem_loader.sv
// Frames an SPI byte stream into memory writes: a header selects the target memory,
// a big-endian 16-bit start address follows, then data bytes are packed MSB-first into words.
module spi_mem_loader #(
   parameter int              WIDTH_SPI_WORD   = 8,
   parameter int              WIDTH_ADDR_ACT   = 12,
   parameter int              WIDTH_ACT_MEM    = 8,
   parameter logic [7:0]      ACT_MEM_HEADER   = 8'b10,
   parameter int              WIDTH_ADDR_PARAM = 13,
   parameter int              WIDTH_PARAM_MEM  = 128,
   parameter logic [7:0]      PARAM_MEM_HEADER = 8'b01,
   parameter int              WIDTH_ADDR_INST  = 6,
   parameter int              WIDTH_INST_MEM   = 80,
   parameter logic [7:0]      INST_MEM_HEADER  = 8'b11
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        frame_start,
   input  logic                        frame_end,
   input  logic                        rx_valid,
   input  logic [WIDTH_SPI_WORD-1:0]   rx_byte,
   output logic [WIDTH_ADDR_ACT-1:0]   act_mem_addr,
   output logic [WIDTH_ACT_MEM-1:0]    act_mem_data,
   output logic                        act_mem_wren,
   output logic [WIDTH_ADDR_PARAM-1:0] param_mem_addr,
   output logic [WIDTH_PARAM_MEM-1:0]  param_mem_data,
   output logic                        param_mem_wren,
   output logic [WIDTH_ADDR_INST-1:0]  inst_mem_addr,
   output logic [WIDTH_INST_MEM-1:0]   inst_mem_data,
   output logic                        inst_mem_wren,
   output logic                        busy,
   output logic                        frame_err
);

   localparam int ADDR_W = (WIDTH_ADDR_ACT > WIDTH_ADDR_PARAM)
                         ? ((WIDTH_ADDR_ACT > WIDTH_ADDR_INST) ? WIDTH_ADDR_ACT : WIDTH_ADDR_INST)
                         : ((WIDTH_ADDR_PARAM > WIDTH_ADDR_INST) ? WIDTH_ADDR_PARAM : WIDTH_ADDR_INST);
   localparam int PACK_W = (WIDTH_ACT_MEM > WIDTH_PARAM_MEM)
                         ? ((WIDTH_ACT_MEM > WIDTH_INST_MEM) ? WIDTH_ACT_MEM : WIDTH_INST_MEM)
                         : ((WIDTH_PARAM_MEM > WIDTH_INST_MEM) ? WIDTH_PARAM_MEM : WIDTH_INST_MEM);
   localparam int ACT_BPW   = WIDTH_ACT_MEM / WIDTH_SPI_WORD;
   localparam int PARAM_BPW = WIDTH_PARAM_MEM / WIDTH_SPI_WORD;
   localparam int INST_BPW  = WIDTH_INST_MEM / WIDTH_SPI_WORD;
   localparam logic [ADDR_W-1:0] ACT_MASK   = ADDR_W'((32'd1 << WIDTH_ADDR_ACT) - 32'd1);
   localparam logic [ADDR_W-1:0] PARAM_MASK = ADDR_W'((32'd1 << WIDTH_ADDR_PARAM) - 32'd1);
   localparam logic [ADDR_W-1:0] INST_MASK  = ADDR_W'((32'd1 << WIDTH_ADDR_INST) - 32'd1);

   typedef enum logic [2:0] {IDLE, HDR, ADDR_HI, ADDR_LO, DATA, DISCARD} state_t;
   typedef enum logic [1:0] {T_ACT, T_PARAM, T_INST} target_t;

   state_t                     state;
   target_t                    target;
   logic [ADDR_W-1:0]          addr;
   logic [WIDTH_SPI_WORD-1:0]  addr_hi;
   logic [4:0]                 cnt;
   // Only the bytes already received are stored; the incoming byte completes shift_nxt.
   logic [PACK_W-WIDTH_SPI_WORD-1:0] shift;

   logic [PACK_W-1:0] shift_nxt;
   logic [4:0]        cnt_nxt;
   logic [4:0]        bpw;
   logic [ADDR_W-1:0] addr_mask;
   logic              word_done;

   assign shift_nxt = {shift, rx_byte};
   assign cnt_nxt   = cnt + 5'd1;
   assign word_done = (cnt_nxt == bpw);
   assign busy      = (state != IDLE);

   always_comb begin
      bpw       = 5'(ACT_BPW);
      addr_mask = ACT_MASK;
      case (target)
         T_PARAM: begin bpw = 5'(PARAM_BPW); addr_mask = PARAM_MASK; end
         T_INST:  begin bpw = 5'(INST_BPW);  addr_mask = INST_MASK;  end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         target         <= T_ACT;
         addr           <= '0;
         addr_hi        <= '0;
         cnt            <= '0;
         shift          <= '0;
         act_mem_addr   <= '0;
         act_mem_data   <= '0;
         act_mem_wren   <= 1'b0;
         param_mem_addr <= '0;
         param_mem_data <= '0;
         param_mem_wren <= 1'b0;
         inst_mem_addr  <= '0;
         inst_mem_data  <= '0;
         inst_mem_wren  <= 1'b0;
         frame_err      <= 1'b0;
      end else begin
         act_mem_wren   <= 1'b0;
         param_mem_wren <= 1'b0;
         inst_mem_wren  <= 1'b0;
         frame_err      <= 1'b0;
         if (frame_start) begin
            frame_err <= (state != IDLE);
            state     <= HDR;
            cnt       <= '0;
         end else begin
            case (state)
               HDR: begin
                  if (frame_end) begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                  end else if (rx_valid) begin
                     if (rx_byte == ACT_MEM_HEADER) begin
                        target <= T_ACT;
                        state  <= ADDR_HI;
                     end else if (rx_byte == PARAM_MEM_HEADER) begin
                        target <= T_PARAM;
                        state  <= ADDR_HI;
                     end else if (rx_byte == INST_MEM_HEADER) begin
                        target <= T_INST;
                        state  <= ADDR_HI;
                     end else begin
                        state     <= DISCARD;
                        frame_err <= 1'b1;
                     end
                  end
               end
               ADDR_HI: begin
                  if (frame_end) begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                  end else if (rx_valid) begin
                     addr_hi <= rx_byte;
                     state   <= ADDR_LO;
                  end
               end
               ADDR_LO: begin
                  if (frame_end) begin
                     state     <= IDLE;
                     frame_err <= 1'b1;
                  end else if (rx_valid) begin
                     addr  <= ADDR_W'({addr_hi, rx_byte}) & addr_mask;
                     cnt   <= '0;
                     state <= DATA;
                  end
               end
               DATA: begin
                  if (rx_valid) begin
                     shift <= shift_nxt[PACK_W-WIDTH_SPI_WORD-1:0];
                     if (word_done) begin
                        // Address advance and counter clear are folded into the write edge
                        // so a byte on the very next cycle starts a fresh word.
                        case (target)
                           T_PARAM: begin
                              param_mem_addr <= addr[WIDTH_ADDR_PARAM-1:0];
                              param_mem_data <= shift_nxt[WIDTH_PARAM_MEM-1:0];
                              param_mem_wren <= 1'b1;
                           end
                           T_INST: begin
                              inst_mem_addr <= addr[WIDTH_ADDR_INST-1:0];
                              inst_mem_data <= shift_nxt[WIDTH_INST_MEM-1:0];
                              inst_mem_wren <= 1'b1;
                           end
                           default: begin
                              act_mem_addr <= addr[WIDTH_ADDR_ACT-1:0];
                              act_mem_data <= shift_nxt[WIDTH_ACT_MEM-1:0];
                              act_mem_wren <= 1'b1;
                           end
                        endcase
                        addr <= (addr + ADDR_W'(1)) & addr_mask;
                        cnt  <= '0;
                        if (frame_end) state <= IDLE;
                     end else begin
                        cnt <= cnt_nxt;
                        if (frame_end) begin
                           state     <= IDLE;
                           frame_err <= 1'b1;
                        end
                     end
                  end else if (frame_end) begin
                     state     <= IDLE;
                     frame_err <= (cnt != 5'd0);
                  end
               end
               DISCARD: if (frame_end) state <= IDLE;
               default: ;
            endcase
         end
      end
   end

endmodule
